dac_write_arbiter: RTL and testbench

DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

---
 rtl/dac_write_arbiter.sv | 111 +++++++++++
 tb/tb_dac_write_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_arbiter.sv
// dac_write_arbiter: round-robin arbiter between calibration and host
// DAC writes, launching one SPI frame at a time with a done timeout.
module dac_write_arbiter #(
  parameter int unsigned TIMEOUT_TICKS = 2000,
  parameter logic [3:0]  CMD           = 4'h3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cal_req,
  input  logic [1:0]  cal_chan,
  input  logic [7:0]  cal_data,
  input  logic        host_req,
  input  logic [1:0]  host_chan,
  input  logic [7:0]  host_data,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        spi_start,
  output logic [15:0] spi_word,
  output logic        cal_ack,
  output logic        host_ack,
  output logic        owner,
  output logic [7:0]  last_code,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    ACK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          prio_host;
  logic          grant;
  logic          grant_host;
  logic          timed_out;

  assign grant      = (state == IDLE) & ~spi_busy
                    & (cal_req | host_req);
  assign grant_host = host_req & (~cal_req | prio_host);
  // A done pulse on the last tick wins over the timeout.
  assign timed_out  = (state == WAIT_DONE) & ~spi_done
                    & (timer == T_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (spi_done || timed_out) state_nxt = ACK;
      ACK:       state_nxt = IDLE;
    endcase
  end

  // Output decode: strobes are pure functions of state and owner.
  always_comb begin
    spi_start = (state == LAUNCH);
    cal_ack   = (state == ACK) & ~owner;
    host_ack  = (state == ACK) &  owner;
  end

  // Latch the winner's frame and flip the tie-break pointer on grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_word  <= 16'h0000;
      owner     <= 1'b0;
      prio_host <= 1'b0;
    end else if (grant) begin
      spi_word  <= grant_host ? {CMD, 2'b00, host_chan, host_data}
                              : {CMD, 2'b00, cal_chan, cal_data};
      owner     <= grant_host;
      prio_host <= ~grant_host;
    end
  end

  // Done-wait timer, cleared at launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (state == LAUNCH) begin
      timer <= '0;
    end else if (state == WAIT_DONE && !spi_done && !timed_out) begin
      timer <= timer + 1'b1;
    end
  end

  // Sticky timeout flag and last completed code.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
      last_code   <= 8'h00;
    end else begin
      if (timed_out)      timeout_err <= 1'b1;
      if (state == ACK)   last_code   <= spi_word[7:0];
    end
  end

endmodule

// File: tb/tb_dac_write_arbiter.sv
// tb_dac_write_arbiter: scoreboard bench for dac_write_arbiter.
// Expected frames are queued at request time and checked at launch.
module tb_dac_write_arbiter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cal_req = 1'b0;
  logic [1:0]  cal_chan = 2'd0;
  logic [7:0]  cal_data = 8'h00;
  logic        host_req = 1'b0;
  logic [1:0]  host_chan = 2'd0;
  logic [7:0]  host_data = 8'h00;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic        spi_start;
  logic [15:0] spi_word;
  logic        cal_ack;
  logic        host_ack;
  logic        owner;
  logic [7:0]  last_code;
  logic        timeout_err;

  typedef struct packed {
    logic        own;
    logic [15:0] word;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_starts = 0;
  int   n_acks = 0;
  bit   model_prio_host = 1'b0;

  dac_write_arbiter #(.TIMEOUT_TICKS(T), .CMD(4'h3)) dut (
    .clk(clk), .reset(reset),
    .cal_req(cal_req), .cal_chan(cal_chan), .cal_data(cal_data),
    .host_req(host_req), .host_chan(host_chan),
    .host_data(host_data),
    .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_start(spi_start), .spi_word(spi_word),
    .cal_ack(cal_ack), .host_ack(host_ack), .owner(owner),
    .last_code(last_code), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [1:0] c,
                                     input logic [7:0] d);
    return {4'h3, 2'b00, c, d};
  endfunction

  task automatic step;
    @(negedge clk);
    if (spi_start === 1'b1) n_starts++;
    if (cal_ack === 1'b1 || host_ack === 1'b1) n_acks++;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    cal_req = 1'b0;
    host_req = 1'b0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    step;
    step;
    reset = 1'b0;
    model_prio_host = 1'b0;
    sb.delete();
  endtask

  task automatic wait_start(input int budget, output int k,
                            output bit seen);
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < budget; i++) begin
      step;
      k++;
      if (spi_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic spi_respond(input int d);
    repeat (d) step;
    spi_done = 1'b1;
    step;
    spi_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cal_req = 1'b1;
    spi_done = 1'b1;
    step;
    step;
    n_cmp++;
    if ({spi_start, cal_ack, host_ack} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 000",
               {spi_start, cal_ack, host_ack});
    end
    n_cmp++;
    if (spi_word !== 16'h0000 || owner !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_word: got %h/%b want 0000/0",
               spi_word, owner);
    end
    n_cmp++;
    if (last_code !== 8'h00 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_status: got %h/%b want 00/0",
               last_code, timeout_err);
    end
    cal_req = 1'b0;
    spi_done = 1'b0;
    step;
    reset = 1'b0;
  endtask

  task automatic test_single_cal;
    int k;
    bit seen;
    exp_t e;
    apply_reset;
    cal_chan = 2'd2;
    cal_data = 8'h5A;
    cal_req = 1'b1;
    sb.push_back({1'b0, mk(2'd2, 8'h5A)});
    wait_start(6, k, seen);
    n_cmp++;
    if (!seen || k != 1) begin
      n_bad++;
      $display("FAIL cal_latency: got seen=%0d k=%0d want k=1",
               seen, k);
    end
    cal_chan = 2'd0;
    cal_data = 8'hFF;
    e = sb.pop_front();
    n_cmp++;
    if (spi_word !== e.word || owner !== e.own) begin
      n_bad++;
      $display("FAIL cal_word: got %h/%b want %h/%b",
               spi_word, owner, e.word, e.own);
    end
    spi_respond(10);
    n_cmp++;
    if (cal_ack !== 1'b1 || host_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cal_ack: got %b%b want 10", cal_ack, host_ack);
    end
    n_cmp++;
    if (spi_word !== 16'h325A) begin
      n_bad++;
      $display("FAIL cal_hold: got %h want 325a", spi_word);
    end
    cal_req = 1'b0;
    step;
    n_cmp++;
    if (last_code !== 8'h5A || cal_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cal_last: got %h/%b want 5a/0",
               last_code, cal_ack);
    end
  endtask

  task automatic test_round_robin;
    int k;
    bit seen;
    bit own;
    exp_t e;
    int s0;
    int a0;
    apply_reset;
    cal_chan = 2'd1;
    cal_data = 8'h11;
    host_chan = 2'd3;
    host_data = 8'h22;
    s0 = n_starts;
    a0 = n_acks;
    cal_req = 1'b1;
    host_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      own = model_prio_host;
      sb.push_back({own, own ? mk(2'd3, 8'h22) : mk(2'd1, 8'h11)});
      model_prio_host = !own;
      wait_start(8, k, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || spi_word !== e.word || owner !== e.own) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %h/%b want %h/%b",
                 i, spi_word, owner, e.word, e.own);
      end
      spi_respond(3);
      n_cmp++;
      if ({cal_ack, host_ack} !== {!own, own}) begin
        n_bad++;
        $display("FAIL rr_ack%0d: got %b%b want %b%b",
                 i, cal_ack, host_ack, !own, own);
      end
      if (own) host_req = 1'b0;
      else     cal_req = 1'b0;
      if (i == 3) begin
        cal_req = 1'b0;
        host_req = 1'b0;
      end
      step;
      if (i < 3) begin
        if (own) host_req = 1'b1;
        else     cal_req = 1'b1;
      end
    end
    repeat (4) step;
    n_cmp++;
    if (n_starts - s0 != 4 || n_acks - a0 != 4) begin
      n_bad++;
      $display("FAIL rr_counts: got starts=%0d acks=%0d want 4/4",
               n_starts - s0, n_acks - a0);
    end
  endtask

  task automatic test_busy;
    int s0;
    exp_t e;
    apply_reset;
    spi_busy = 1'b1;
    host_chan = 2'd0;
    host_data = 8'hA5;
    host_req = 1'b1;
    sb.push_back({1'b1, mk(2'd0, 8'hA5)});
    s0 = n_starts;
    repeat (50) step;
    n_cmp++;
    if (n_starts != s0) begin
      n_bad++;
      $display("FAIL busy_hold: got %0d starts want 0",
               n_starts - s0);
    end
    spi_busy = 1'b0;
    step;
    n_cmp++;
    if (spi_start !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_release: got start=%b want 1", spi_start);
    end
    e = sb.pop_front();
    n_cmp++;
    if (spi_word !== e.word || owner !== e.own) begin
      n_bad++;
      $display("FAIL busy_word: got %h/%b want %h/%b",
               spi_word, owner, e.word, e.own);
    end
    spi_respond(2);
    n_cmp++;
    if (host_ack !== 1'b1 || cal_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ack: got %b%b want 01", cal_ack, host_ack);
    end
    host_req = 1'b0;
    step;
  endtask

  task automatic test_timeout;
    int k;
    bit seen;
    bit err_early;
    exp_t e;
    apply_reset;
    cal_chan = 2'd1;
    cal_data = 8'h77;
    cal_req = 1'b1;
    sb.push_back({1'b0, mk(2'd1, 8'h77)});
    wait_start(6, k, seen);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || spi_word !== e.word) begin
      n_bad++;
      $display("FAIL to_word: got %h want %h", spi_word, e.word);
    end
    k = 0;
    seen = 1'b0;
    err_early = 1'b0;
    for (int i = 0; i < T + 10; i++) begin
      step;
      k++;
      if (cal_ack === 1'b1 || host_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (timeout_err !== 1'b0) err_early = 1'b1;
    end
    n_cmp++;
    if (!seen || k != T + 1) begin
      n_bad++;
      $display("FAIL to_cycles: got seen=%0d k=%0d want k=%0d",
               seen, k, T + 1);
    end
    n_cmp++;
    if (err_early) begin
      n_bad++;
      $display("FAIL to_early: got early err=1 want 0");
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || cal_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL to_flag: got err=%b ack=%b want 1/1",
               timeout_err, cal_ack);
    end
    cal_req = 1'b0;
    step;
    host_chan = 2'd2;
    host_data = 8'h3C;
    host_req = 1'b1;
    sb.push_back({1'b1, mk(2'd2, 8'h3C)});
    wait_start(6, k, seen);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || spi_word !== e.word || owner !== e.own) begin
      n_bad++;
      $display("FAIL to_next: got %h/%b want %h/%b",
               spi_word, owner, e.word, e.own);
    end
    spi_respond(4);
    n_cmp++;
    if (host_ack !== 1'b1 || timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: got ack=%b err=%b want 1/1",
               host_ack, timeout_err);
    end
    host_req = 1'b0;
    step;
    n_cmp++;
    if (last_code !== 8'h3C) begin
      n_bad++;
      $display("FAIL to_last: got %h want 3c", last_code);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    bit seen;
    int s0;
    int a0;
    cal_chan = 2'd3;
    cal_data = 8'h99;
    cal_req = 1'b1;
    wait_start(6, k, seen);
    repeat (3) step;
    s0 = n_starts;
    a0 = n_acks;
    reset = 1'b1;
    cal_req = 1'b0;
    step;
    reset = 1'b0;
    spi_done = 1'b1;
    n_cmp++;
    if ({spi_start, cal_ack, host_ack, owner, timeout_err} !== 5'b0 ||
        spi_word !== 16'h0000 || last_code !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset: got %b %h %h want 00000 0000 00",
               {spi_start, cal_ack, host_ack, owner, timeout_err},
               spi_word, last_code);
    end
    step;
    spi_done = 1'b0;
    repeat (5) step;
    n_cmp++;
    if (n_acks != a0 || n_starts != s0) begin
      n_bad++;
      $display("FAIL mid_abandon: got acks=%0d starts=%0d want 0/0",
               n_acks - a0, n_starts - s0);
    end
  endtask

  task automatic test_done_at_limit;
    int k;
    bit seen;
    exp_t e;
    apply_reset;
    cal_chan = 2'd0;
    cal_data = 8'hC3;
    cal_req = 1'b1;
    sb.push_back({1'b0, mk(2'd0, 8'hC3)});
    wait_start(6, k, seen);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || spi_word !== e.word) begin
      n_bad++;
      $display("FAIL lim_word: got %h want %h", spi_word, e.word);
    end
    spi_respond(T);
    n_cmp++;
    if (cal_ack !== 1'b1 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL lim_ack: got ack=%b err=%b want 1/0",
               cal_ack, timeout_err);
    end
    cal_req = 1'b0;
    step;
    n_cmp++;
    if (last_code !== 8'hC3 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL lim_last: got %h/%b want c3/0",
               last_code, timeout_err);
    end
  endtask

  initial begin
    test_reset;
    test_single_cal;
    test_round_robin;
    test_busy;
    test_timeout;
    test_reset_mid;
    test_done_at_limit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
